app_scheduler: RTL and testbench

APP_SCHEDULER -- requirements
Module: app_scheduler

---
 rtl/app_scheduler.sv | 116 +++++++++++
 tb/tb_app_scheduler.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/app_scheduler.sv
// Top-level mode scheduler: routes button pulses between the menu and the active app.
// Optional idle return to MENU is built only when APP_IDLE_TIMEOUT_EN is defined.
module app_scheduler #(
  parameter int unsigned HOLD_CYCLES = 2000,
  parameter int unsigned IDLE_CYCLES = 30000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn_in,
  input  logic [1:0] menu_sel,
  input  logic [2:0] app_ended,
  output logic [3:0] state,
  output logic [4:0] menu_btn,
  output logic [4:0] app_btn,
  output logic [2:0] app_start
);

  localparam logic [3:0] S_MENU    = 4'd0;
  localparam logic [3:0] S_VOLUME  = 4'd1;
  localparam logic [3:0] S_POKEMON = 4'd2;
  localparam logic [3:0] S_FRUIT   = 4'd3;
  localparam logic [3:0] S_POTION  = 4'd4;
  localparam logic [3:0] S_OVER    = 4'd5;

  localparam logic [15:0] HOLD_MAX = 16'(HOLD_CYCLES);

  logic [3:0]  state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic [2:0]  start_q, start_d;
  logic        btn_c;
  logic        idle_timeout;

  assign btn_c = btn_in[4];

`ifdef APP_IDLE_TIMEOUT_EN
  localparam logic [31:0] IDLE_MAX = 32'(IDLE_CYCLES);

  logic [31:0] idle_q, idle_d;

  // Any button pulse in the expiry cycle keeps the user in the current mode.
  assign idle_timeout = (idle_q == IDLE_MAX) && (btn_in == 5'd0) && (state_q != S_MENU);

  always_comb begin
    idle_d = idle_q;
    if ((btn_in != 5'd0) || (state_d != state_q)) begin
      idle_d = '0;
    end else if (idle_q < IDLE_MAX) begin
      idle_d = idle_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign idle_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_MENU:    if (btn_c) state_d = {2'b00, menu_sel} + 4'd1;
      S_VOLUME:  if (btn_c) state_d = S_MENU;
      S_POKEMON: if (app_ended[0]) state_d = S_OVER;
      S_FRUIT:   if (app_ended[1]) state_d = S_OVER;
      S_POTION:  if (app_ended[2]) state_d = S_OVER;
      S_OVER:    if (btn_c && (hold_q == HOLD_MAX)) state_d = S_MENU;
      default:   state_d = S_MENU;
    endcase
    if (idle_timeout) begin
      state_d = S_MENU;
    end
  end

  // Hold count is only meaningful in OVER; outside it stays zero so entry starts from 0.
  always_comb begin
    hold_d = '0;
    if (state_q == S_OVER) begin
      hold_d = (hold_q < HOLD_MAX) ? hold_q + 16'd1 : hold_q;
    end
  end

  always_comb begin
    start_d = 3'b000;
    if (state_d != state_q) begin
      case (state_d)
        S_POKEMON: start_d = 3'b001;
        S_FRUIT:   start_d = 3'b010;
        S_POTION:  start_d = 3'b100;
        default:   start_d = 3'b000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_MENU;
      hold_q  <= '0;
      start_q <= 3'b000;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      start_q <= start_d;
    end
  end

  assign state     = state_q;
  assign app_start = start_q;
  assign menu_btn  = (state_q == S_MENU) ? btn_in : 5'd0;
  assign app_btn   = ((state_q >= S_VOLUME) && (state_q <= S_POTION)) ? btn_in : 5'd0;

endmodule

// File: tb/tb_app_scheduler.sv
// Bench for app_scheduler: directed literal scenarios followed by randomized traffic,
// all checked against a mode-level reference model every cycle.
module tb_app_scheduler;

  localparam int MENU    = 0;
  localparam int VOLUME  = 1;
  localparam int POKEMON = 2;
  localparam int FRUIT   = 3;
  localparam int POTION  = 4;
  localparam int OVER    = 5;
  localparam int HOLD    = 2000;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btnIn;
  logic [1:0] menuSel;
  logic [2:0] appEnded;
  logic [3:0] state;
  logic [4:0] menuBtn;
  logic [4:0] appBtn;
  logic [2:0] appStart;

  int total = 0;
  int bad   = 0;
  logic checkEn = 1'b0;

  int mState;
  int mAge;
  logic [2:0] mStart;

  logic [4:0] rb;
  logic [2:0] re;

  app_scheduler #(.HOLD_CYCLES(HOLD), .IDLE_CYCLES(30000)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btnIn),
    .menu_sel  (menuSel),
    .app_ended (appEnded),
    .state     (state),
    .menu_btn  (menuBtn),
    .app_btn   (appBtn),
    .app_start (appStart)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Mode rules: the menu cursor picks mode sel+1, games end into OVER, OVER needs HOLD cycles before C exits.
  function automatic int modelNext(int s, int age, logic [4:0] b, logic [1:0] sel, logic [2:0] e);
    int n;
    n = s;
    if (s == MENU && b[4]) n = 1 + int'(sel);
    else if (s == VOLUME && b[4]) n = MENU;
    else if (s >= POKEMON && s <= POTION && e[s - POKEMON]) n = OVER;
    else if (s == OVER && b[4] && age >= HOLD) n = MENU;
    return n;
  endfunction

  function automatic logic [2:0] startFor(int cur, int nxt);
    if (nxt != cur && nxt >= POKEMON && nxt <= POTION) return 3'(1 << (nxt - POKEMON));
    return 3'b000;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mState <= MENU;
      mAge   <= 0;
      mStart <= 3'b000;
    end else begin
      mState <= modelNext(mState, mAge, btnIn, menuSel, appEnded);
      mAge   <= (mState == OVER && modelNext(mState, mAge, btnIn, menuSel, appEnded) == OVER) ? mAge + 1 : 0;
      mStart <= startFor(mState, modelNext(mState, mAge, btnIn, menuSel, appEnded));
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model_state", {12'd0, state}, 16'(mState));
      checkOutput("model_start", {13'd0, appStart}, {13'd0, mStart});
      checkOutput("model_menu_btn", {11'd0, menuBtn}, {11'd0, (mState == MENU) ? btnIn : 5'd0});
      checkOutput("model_app_btn", {11'd0, appBtn},
                  {11'd0, (mState >= VOLUME && mState <= POTION) ? btnIn : 5'd0});
    end
  end

  task automatic applyStimulus(input logic [4:0] b, input logic [1:0] s, input logic [2:0] e);
    @(posedge clk);
    #1;
    btnIn    = b;
    menuSel  = s;
    appEnded = e;
  endtask

  task automatic settle();
    #5;
  endtask

  initial begin
    rst = 1'b0;
    btnIn = 5'b00100;
    menuSel = 2'b00;
    appEnded = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", {12'd0, state}, 16'd0);
    checkOutput("reset_start", {13'd0, appStart}, 16'd0);
    checkOutput("reset_menu_btn", {11'd0, menuBtn}, 16'h0004);
    checkOutput("reset_app_btn", {11'd0, appBtn}, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    btnIn = 5'b00000;
    checkEn = 1'b1;

    // Start pokemon from the menu.
    applyStimulus(5'b10000, 2'b01, 3'b000);
    settle();
    checkOutput("menu_c_state", {12'd0, state}, 16'd0);
    checkOutput("menu_c_fwd", {11'd0, menuBtn}, 16'h0010);
    applyStimulus(5'b00000, 2'b01, 3'b000);
    settle();
    checkOutput("poke_state", {12'd0, state}, 16'd2);
    checkOutput("poke_start", {13'd0, appStart}, 16'h0001);
    applyStimulus(5'b00000, 2'b01, 3'b010);
    settle();
    checkOutput("poke_start_clear", {13'd0, appStart}, 16'd0);
    applyStimulus(5'b10000, 2'b01, 3'b001);
    settle();
    checkOutput("poke_other_ended", {12'd0, state}, 16'd2);
    checkOutput("poke_c_fwd", {11'd0, appBtn}, 16'h0010);
    applyStimulus(5'b00000, 2'b01, 3'b000);
    settle();
    checkOutput("ended_to_over", {12'd0, state}, 16'd5);

    // Hold boundary: C in OVER cycle 1999 is dropped, cycle 2000 exits.
    repeat (1998) applyStimulus(5'b00000, 2'b00, 3'b000);
    applyStimulus(5'b10000, 2'b00, 3'b000);
    settle();
    checkOutput("over_1999_menu_btn", {11'd0, menuBtn}, 16'd0);
    checkOutput("over_1999_app_btn", {11'd0, appBtn}, 16'd0);
    applyStimulus(5'b10000, 2'b00, 3'b000);
    settle();
    checkOutput("over_1999_stay", {12'd0, state}, 16'd5);
    applyStimulus(5'b00000, 2'b00, 3'b000);
    settle();
    checkOutput("over_2000_exit", {12'd0, state}, 16'd0);

    // Volume round trip.
    applyStimulus(5'b10000, 2'b00, 3'b000);
    applyStimulus(5'b00000, 2'b00, 3'b000);
    settle();
    checkOutput("vol_state", {12'd0, state}, 16'd1);
    checkOutput("vol_start", {13'd0, appStart}, 16'd0);
    applyStimulus(5'b01000, 2'b00, 3'b111);
    settle();
    checkOutput("vol_up_fwd", {11'd0, appBtn}, 16'h0008);
    applyStimulus(5'b10000, 2'b00, 3'b000);
    applyStimulus(5'b00000, 2'b00, 3'b000);
    settle();
    checkOutput("vol_exit", {12'd0, state}, 16'd0);

    // Asynchronous reset in the middle of fruit ninja.
    applyStimulus(5'b10000, 2'b10, 3'b000);
    applyStimulus(5'b00000, 2'b10, 3'b000);
    settle();
    checkOutput("fruit_start", {13'd0, appStart}, 16'h0002);
    applyStimulus(5'b01000, 2'b10, 3'b000);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_state", {12'd0, state}, 16'd0);
    checkOutput("async_rst_app_btn", {11'd0, appBtn}, 16'd0);
    checkOutput("async_rst_menu_btn", {11'd0, menuBtn}, 16'h0008);
    applyStimulus(5'b00000, 2'b10, 3'b000);
    rst = 1'b1;
    applyStimulus(5'b00000, 2'b10, 3'b000);
    settle();
    checkOutput("rel_state", {12'd0, state}, 16'd0);
    checkOutput("rel_no_start", {13'd0, appStart}, 16'd0);

    for (int i = 0; i < 14000; i++) begin
      rb[4] = ($urandom_range(0, 4) == 0);
      for (int k = 0; k < 4; k++) rb[k] = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < 3; k++) re[k] = ($urandom_range(0, 29) == 0);
      applyStimulus(rb, 2'($urandom_range(0, 3)), re);
      if (!rst) rst = 1'b1;
      if ($urandom_range(0, 2999) == 0) begin
        #2;
        rst = 1'b0;
      end
    end
    applyStimulus(5'b00000, 2'b00, 3'b000);
    rst = 1'b1;
    settle();
    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
